// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one minterm-decoded full adder reused over WIDTH cycles,
// LSB first, with a three-state IDLE/RUN/DONE controller.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [7:0]       m
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [7:0] dec;
    logic [2:0] idx;
    logic       s_bit;
    logic       c_bit;

    // Full adder as a 3:8 one-hot decode; a_bit is the MSB of the index
    always_comb begin
        idx   = {a_sh_q[0], b_sh_q[0], carry_q};
        dec   = 8'b0000_0001 << idx;
        s_bit = dec[1] | dec[2] | dec[4] | dec[7];
        c_bit = dec[3] | dec[5] | dec[6] | dec[7];
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = {s_bit, res_q[WIDTH-1:1]};
                carry_d = c_bit;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = {s_bit, res_q[WIDTH-1:1]};
                    cout_d  = c_bit;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign m    = (state_q == RUN) ? dec : 8'h00;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed scenarios plus a
// scoreboard of expected {cout,sum} popped on every done pulse.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic [7:0]   m;

    int checks;
    int failures;
    int done_cnt;
    int acc_cnt;

    logic [W:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .m     (m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every done pulse must match the oldest outstanding op
    always @(negedge clk) begin
        if (rst_n && done) begin
            logic [W:0] e;
            done_cnt++;
            checks++;
            if (busy) begin
                failures++;
                $display("FAIL busy_done_overlap busy=%0b done=%0b", busy, done);
            end
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_done got=%0h%0h required=none",
                         cout, sum);
            end else begin
                e = exp_q.pop_front();
                if ({cout, sum} !== e) begin
                    failures++;
                    $display("FAIL sb_result got=%h required=%h",
                             {cout, sum}, e);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (busy || done) begin
            checks++;
            failures++;
            $display("FAIL wait_idle_timeout busy=%0b done=%0b", busy, done);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL wait_done_timeout done=%0b required=1", done);
        end
    endtask

    // Issue one op; operands are scrambled after acceptance
    task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic ic);
        wait_idle();
        a     = ia;
        b     = ib;
        cin   = ic;
        start = 1'b1;
        exp_q.push_back({1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic});
        acc_cnt++;
        @(negedge clk);
        start = 1'b0;
        a     = ~ia;
        b     = ~ib;
        cin   = ~ic;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, cout, sum, m} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h required=0",
                     {busy, done, cout, sum, m});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release got=%b required=00", {busy, done});
        end
    endtask

    task automatic test_basic();
        int n = 0;
        op(8'h5A, 8'h3C, 1'b0);
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != W) begin
            failures++;
            $display("FAIL basic_busy_cycles got=%0d required=%0d", n, W);
        end
        checks++;
        if (done !== 1'b1 || sum !== 8'h96 || cout !== 1'b0) begin
            failures++;
            $display("FAIL basic_result done=%0b sum=%h cout=%0b required=1 96 0",
                     done, sum, cout);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse got=%0b required=0", done);
        end
    endtask

    task automatic test_hold();
        int n = 0;
        op(8'hFF, 8'hFF, 1'b1);
        while (busy && n < 20) begin
            checks++;
            if (sum !== 8'h96 || cout !== 1'b0) begin
                failures++;
                $display("FAIL hold_prev sum=%h cout=%0b required=96 0",
                         sum, cout);
            end
            n++;
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || sum !== 8'hFF || cout !== 1'b1) begin
            failures++;
            $display("FAIL hold_result done=%0b sum=%h cout=%0b required=1 ff 1",
                     done, sum, cout);
        end
    endtask

    task automatic test_minterm();
        int n = 0;
        logic [7:0] em;
        op(8'hFF, 8'h01, 1'b0);
        while (busy && n < 20) begin
            // bit0 is {1,1,0} -> m[6]; later bits {1,0,1} -> m[5]
            em = (n == 0) ? 8'h40 : 8'h20;
            checks++;
            if (m !== em) begin
                failures++;
                $display("FAIL minterm_bit%0d got=%h required=%h", n, m, em);
            end
            n++;
            @(negedge clk);
        end
        checks++;
        if (m !== 8'h00 || sum !== 8'h00 || cout !== 1'b1) begin
            failures++;
            $display("FAIL minterm_done m=%h sum=%h cout=%0b required=00 00 1",
                     m, sum, cout);
        end
    endtask

    task automatic test_start_held();
        wait_idle();
        a     = 8'h10;
        b     = 8'h20;
        cin   = 1'b0;
        start = 1'b1;
        exp_q.push_back(9'h030);
        acc_cnt++;
        @(negedge clk);
        a   = 8'h01;
        b   = 8'h02;
        cin = 1'b1;
        exp_q.push_back(9'h004);
        acc_cnt++;
        wait_done();
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL held_idle_gap got=%b required=00", {busy, done});
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL held_reaccept busy=%0b required=1", busy);
        end
        start = 1'b0;
        a     = 8'hEE;
        b     = 8'hEE;
        wait_done();
        checks++;
        if (sum !== 8'h04 || cout !== 1'b0) begin
            failures++;
            $display("FAIL held_second sum=%h cout=%0b required=04 0",
                     sum, cout);
        end
    endtask

    task automatic test_reset_mid_run();
        op(8'h5A, 8'h3C, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, cout, sum, m} !== '0) begin
            failures++;
            $display("FAIL midrun_reset got=%h required=0",
                     {busy, done, cout, sum, m});
        end
        exp_q.delete();
        acc_cnt--;
        @(negedge clk);
        rst_n = 1'b1;
        a     = 8'h01;
        b     = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        exp_q.push_back(9'h002);
        acc_cnt++;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midrun_first_edge busy=%0b required=1", busy);
        end
        wait_done();
        checks++;
        if (sum !== 8'h02 || cout !== 1'b0) begin
            failures++;
            $display("FAIL midrun_fresh sum=%h cout=%0b required=02 0",
                     sum, cout);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            op(W'($urandom), W'($urandom), 1'($urandom));
        end
        wait_done();
        @(negedge clk);
        checks++;
        if (done_cnt != acc_cnt || exp_q.size() != 0) begin
            failures++;
            $display("FAIL random_count dones=%0d required=%0d left=%0d",
                     done_cnt, acc_cnt, exp_q.size());
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        done_cnt = 0;
        acc_cnt  = 0;
        test_reset();
        test_basic();
        test_hold();
        test_minterm();
        test_start_held();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
